// File: rtl/shifter8b_right_seq.sv
// shifter8b_right_seq
//   Iterative right shifter. A start accepted in IDLE captures the operand,
//   the shift amount and the mode. The block then shifts one bit per clock
//   and raises done for a single cycle when the result is on y.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only in IDLE
//   a      operand (WIDTH), captured on the accepting edge
//   s      shift amount (SW), captured on the accepting edge
//   mode   00 logical, 01 arithmetic, 10 rotate right, 11 logical
//   busy   high whenever the state is not IDLE
//   done   one-cycle completion pulse
//   y      working/result register; it holds the last result while idle
module shifter8b_right_seq #(
  parameter int WIDTH = 8,
  parameter int SW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    s,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [SW-1:0]    cnt, cnt_nxt;
  logic [1:0]       md, md_nxt;
  logic [WIDTH-1:0] y_nxt, shr;
  logic             fill;

  // Bit shifted into the MSB. The reserved mode 11 falls into the
  // logical default.
  always_comb begin
    fill = 1'b0;
    case (md)
      2'b01:   fill = y[WIDTH-1];
      2'b10:   fill = y[0];
      default: fill = 1'b0;
    endcase
  end

  // One-position right shift. Each lane takes its upper neighbour.
  // The top lane takes the fill bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    if (i == WIDTH-1) begin : g_top
      assign shr[i] = fill;
    end else begin : g_mid
      assign shr[i] = y[i+1];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    md_nxt    = md;
    y_nxt     = y;
    case (state)
      IDLE: begin
        if (start) begin
          y_nxt     = a;
          cnt_nxt   = s;
          md_nxt    = mode;
          state_nxt = (s == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        y_nxt   = shr;
        cnt_nxt = cnt - 1'b1;
        if (cnt == SW'(1)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      md    <= 2'b00;
      y     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      md    <= md_nxt;
      y     <= y_nxt;
    end
  end

  // Both flags are decoded from the state register only. Nothing in start
  // reaches them combinationally.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shifter8b_right_seq.sv
module tb_shifter8b_right_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [2:0] s = '0;
  logic [1:0] mode = '0;
  logic       busy, done;
  logic [7:0] y;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  logic [7:0] exp_q[$];

  shifter8b_right_seq #(.WIDTH(8), .SW(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .s(s), .mode(mode),
    .busy(busy), .done(done), .y(y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] av, input logic [2:0] sv,
                                       input logic [1:0] mv);
    logic [15:0] dbl;
    case (mv)
      2'b01:   model = 8'($signed(av) >>> sv);
      2'b10: begin
        dbl   = {av, av} >> sv;
        model = dbl[7:0];
      end
      default: model = av >> sv;
    endcase
  endfunction

  // Result monitor: each done pulse pops one expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      chk("done_width", {31'b0, prev_done}, 0);
      if (exp_q.size() == 0) chk("spurious_done", 1, 0);
      else chk("y_result", y, exp_q.pop_front());
    end
    prev_done = done;
  end

  // Launch one operation and check the handshake timing.
  task automatic op(input logic [7:0] av, input logic [2:0] sv, input logic [1:0] mv,
                    input logic [7:0] ev);
    int n;
    @(negedge clk);
    a = av; s = sv; mode = mv; start = 1'b1;
    exp_q.push_back(ev);
    @(negedge clk);                 // edge 0 has passed
    start = 1'b0; a = 8'hxx; s = 3'($urandom); mode = 2'($urandom);
    chk("busy_after_accept", busy, 1);
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("done_latency", n, sv);
    chk("busy_in_done", busy, 1);
    @(negedge clk);
    chk("busy_fall", busy, 0);
    chk("done_fall", done, 0);
    chk("y_hold", y, ev);
  endtask

  initial begin
    int n, d0;
    logic [7:0] ra; logic [2:0] rs; logic [1:0] rm;
    #1;
    chk("rst_y", y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    op(8'b00011000, 3'd3, 2'b00, 8'b00000011);
    op(8'h98, 3'd2, 2'b01, 8'hE6);
    op(8'h98, 3'd7, 2'b01, 8'hFF);
    op(8'h81, 3'd1, 2'b10, 8'hC0);
    op(8'h18, 3'd7, 2'b10, 8'h30);
    op(8'hA5, 3'd0, 2'b00, 8'hA5);
    op(8'h80, 3'd4, 2'b11, 8'h08);

    // Busy rejection: start pulses during SHIFT and during DONE are ignored.
    d0 = done_cnt;
    @(negedge clk);
    a = 8'hF0; s = 3'd5; mode = 2'b00; start = 1'b1;
    exp_q.push_back(8'h07);
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 8'h0F; s = 3'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("rej_timeout", {31'b0, done}, 1);
    start = 1'b1; a = 8'h0F; s = 3'd0;
    @(negedge clk); start = 1'b0;
    chk("rej_busy_after_done", busy, 0);
    repeat (3) @(negedge clk);
    chk("rej_y", y, 8'h07);
    chk("rej_done_count", done_cnt - d0, 1);
    chk("rej_idle", busy, 0);

    // Reset abort at edge 2 of an s=6 operation.
    d0 = done_cnt;
    @(negedge clk);
    a = 8'hFF; s = 3'd6; mode = 2'b01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_y", y, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", busy, 0);
    op(8'h40, 3'd6, 2'b00, 8'h01);

    // Random sweep against the closed-form model.
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom); rs = 3'($urandom); rm = 2'($urandom);
      op(ra, rs, rm, model(ra, rs, rm));
    end

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
